mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Sequencer for the tiny MIPS test system. It holds the 8-bit core in reset, streams a program image byte by byte into the shared single-port program/data memory, and releases the core. It then monitors the core's memory writes for the halt store and flags done, or flags timeout if a watchdog expires. It sits between the `mips` core, the `exmem` RAM and a host byte stream, and owns the RAM's write/address port.

## Interface
- WIDTH, 8, data width of core and RAM
- RAM_ADDR_BITS, 8, RAM address width
- HALT_ADR, 8'hFF, core store to this address ends the run
- HOLD_CYCLES, 2, cycles core reset is held after load/before run (≥1)
- MAX_CYCLES, 1024, watchdog limit in RUN cycles (≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  pulse: begin program load
- run_start  in  1  pulse: rerun current image without reload
- in_valid  in  1  host byte valid
- in_data  in  WIDTH  host byte
- in_last  in  1  final byte of image
- in_ready  out  1  controller accepts byte
- cpu_memwrite  in  1  core write strobe
- cpu_adr  in  RAM_ADDR_BITS  core address
- cpu_writedata  in  WIDTH  core write data
- cpu_reset  out  1  reset to core
- mem_memwrite  out  1  RAM write strobe
- mem_adr  out  RAM_ADDR_BITS  RAM address
- mem_writedata  out  WIDTH  RAM write data
- load_count  out  RAM_ADDR_BITS+1  bytes written by last load
- result  out  WIDTH  data of halt store
- cycles  out  log2(MAX_CYCLES)+1  RUN cycles of last run
- done  out  1  run ended by halt store
- timeout  out  1  run ended by watchdog

## Operation
- States: IDLE, LOAD, HOLD, RUN, DONE, TIMEOUT. Reset → IDLE. All counters and outputs are 0 except cpu_reset = 1.
- IDLE/DONE/TIMEOUT:
  - load_start → LOAD, clears load address and load_count.
  - Else run_start → HOLD.
  - load_start wins when both are pulsed in the same cycle.
  - Either transition clears done, timeout and result.
- LOAD:
  - in_ready = 1. On in_valid, write in_data to the load address, then increment the address and load_count.
  - in_last, or a write to address 2^RAM_ADDR_BITS−1, → HOLD. A 256-byte image fills the RAM exactly. The stream is then closed: in_ready = 0 and excess bytes are not accepted.
  - load_start/run_start are ignored in LOAD.
- HOLD: waits HOLD_CYCLES cycles. The final negedge RAM write lands before the core leaves reset. The cycle counter is cleared. → RUN.
- RUN:
  - cpu_reset = 0. cycles increments every RUN cycle.
  - A core store with cpu_adr == HALT_ADR captures result = cpu_writedata, then → DONE, done = 1. The store is still forwarded to RAM.
  - If no halt occurs and the count reaches MAX_CYCLES−1, → TIMEOUT, timeout = 1.
  - Halt and watchdog expiry in the same cycle resolve as DONE.
- cpu_reset = 1 in every state except RUN. It is decoded from the registered state, with no combinational input path.
- RAM port mux, combinational from the registered state:
  - RUN: pass the cpu_* signals through.
  - LOAD: mem_memwrite = in_valid, mem_adr = load address, mem_writedata = in_data.
  - Otherwise: mem_memwrite = 0, mem_adr = 0, mem_writedata = 0.
- RAM read data goes directly to the core and does not pass through this block.
- Reset mid-operation: immediate return to IDLE with reset values on all outputs. RAM contents are not cleared.

## Timing
- All state and registers update on the rising edge of clk. The RAM samples on the falling edge, so mux outputs must be stable by mid-cycle.
- A byte is accepted in the cycle where in_valid & in_ready are both high. Throughput is 1 byte per cycle.
- in_last accepted in cycle t → HOLD at t+1 → RUN at t+1+HOLD_CYCLES.
- The first cycle with cpu_reset = 0 is the first RUN cycle, with cycles = 0 during it.
- Halt store in RUN cycle n → DONE, done = 1, result valid and cycles = n+1 at the next edge.
- With no halt, RUN lasts exactly MAX_CYCLES cycles.
- done and timeout stay high until the next load_start/run_start or reset.

## Structure
- The shared package `mips_pkg` holds:
  - the state enum `run_state_t`
  - the HALT_ADR default
  - the width helper for `cycles`
- One sub-module, `run_watchdog`, holds the clearable, enabled cycle counter with a terminal-count flag (MAX_CYCLES−1).
- The state machine, load address counter and RAM mux stay in `mips_run_ctrl`.

## Test plan
- Fibonacci image, 64 bytes streamed back-to-back with in_last on the final byte:
  - load_count = 64.
  - cpu_reset falls HOLD_CYCLES+1 cycles after in_last.
  - The core stores 8'h0D to 8'hFF.
  - Required: done = 1, result = 8'h0D, timeout = 0, and RAM[FF] = 0D.
- Image of 256+4 bytes with no in_last:
  - in_ready drops after byte 256 and load_count = 256.
  - HOLD is entered automatically and the extra bytes are never written.
- Looping image with no halt store, MAX_CYCLES = 16:
  - timeout = 1, cycles = 16, done = 0.
  - cpu_reset is reasserted on the 17th cycle.
- Halt store placed on the cycle where the watchdog count reaches MAX_CYCLES−1:
  - Required: done = 1, timeout = 0, result captured.
- Same cycle load_start + run_start in DONE:
  - LOAD is entered and done clears.
  - A subsequent run_start from DONE reruns without reload and gives an identical result and cycles.
- reset asserted for 1 cycle midway through LOAD and again midway through RUN:
  - IDLE is entered, cpu_reset = 1 and all status outputs are 0.
  - Bytes already written remain in RAM.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and helpers for the tiny MIPS test system
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_t;

    localparam logic [7:0] HALT_ADR_DEFAULT = 8'hFF;

    // Wide enough to hold MAX_CYCLES itself, the value left after a full-length run.
    function automatic int cycles_width(input int max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - host byte stream, core bus and RAM port of the run controller
interface mips_run_ctrl_if #(
    parameter int WIDTH         = 8,
    parameter int RAM_ADDR_BITS = 8
);
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_last;
    logic                     in_ready;

    logic                     cpu_memwrite;
    logic [RAM_ADDR_BITS-1:0] cpu_adr;
    logic [WIDTH-1:0]         cpu_writedata;

    logic                     mem_memwrite;
    logic [RAM_ADDR_BITS-1:0] mem_adr;
    logic [WIDTH-1:0]         mem_writedata;

    modport slave (
        input  in_valid, in_data, in_last, cpu_memwrite, cpu_adr, cpu_writedata,
        output in_ready, mem_memwrite, mem_adr, mem_writedata
    );

    modport master (
        output in_valid, in_data, in_last, cpu_memwrite, cpu_adr, cpu_writedata,
        input  in_ready, mem_memwrite, mem_adr, mem_writedata
    );
endinterface

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - clearable RUN-cycle counter with terminal-count flag
module run_watchdog
    import mips_pkg::*;
#(
    parameter int MAX_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clr,
    input  logic                                 en,
    output logic [cycles_width(MAX_CYCLES)-1:0]  count,
    output logic                                 tc
);
    localparam int CW = cycles_width(MAX_CYCLES);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(MAX_CYCLES - 1));
endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - loads a program image into RAM, runs the core, detects halt/timeout
module mips_run_ctrl
    import mips_pkg::*;
#(
    parameter int                       WIDTH         = 8,
    parameter int                       RAM_ADDR_BITS = 8,
    parameter logic [RAM_ADDR_BITS-1:0] HALT_ADR      = RAM_ADDR_BITS'(HALT_ADR_DEFAULT),
    parameter int                       HOLD_CYCLES   = 2,
    parameter int                       MAX_CYCLES    = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_start,
    input  logic                                run_start,
    mips_run_ctrl_if.slave                      bus,
    output logic                                cpu_reset,
    output logic [RAM_ADDR_BITS:0]              load_count,
    output logic [WIDTH-1:0]                    result,
    output logic [cycles_width(MAX_CYCLES)-1:0] cycles,
    output logic                                done,
    output logic                                timeout
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    run_state_t               state;
    logic [RAM_ADDR_BITS-1:0] load_adr;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     wd_tc;
    logic                     halt_hit;

    run_watchdog #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_watchdog (
        .clk  (clk),
        .reset(reset),
        .clr  (state == ST_HOLD),
        .en   (state == ST_RUN),
        .count(cycles),
        .tc   (wd_tc)
    );

    assign halt_hit = bus.cpu_memwrite && (bus.cpu_adr == HALT_ADR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            load_adr   <= '0;
            load_count <= '0;
            hold_cnt   <= '0;
            result     <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (load_start || run_start) begin
                        done    <= 1'b0;
                        timeout <= 1'b0;
                        result  <= '0;
                    end
                    if (load_start) begin
                        state      <= ST_LOAD;
                        load_adr   <= '0;
                        load_count <= '0;
                    end else if (run_start) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        load_adr   <= load_adr + 1'b1;
                        load_count <= load_count + 1'b1;
                        // Writing the top address fills the RAM; the stream closes either way.
                        if (bus.in_last || (load_adr == '1)) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_hit) begin
                        result <= bus.cpu_writedata;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (wd_tc) begin
                        timeout <= 1'b1;
                        state   <= ST_TIMEOUT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_reset    = (state != ST_RUN);
    assign bus.in_ready = (state == ST_LOAD);

    // RAM samples on the falling edge, so this mux only depends on the registered state.
    always_comb begin
        bus.mem_memwrite  = 1'b0;
        bus.mem_adr       = '0;
        bus.mem_writedata = '0;
        case (state)
            ST_RUN: begin
                bus.mem_memwrite  = bus.cpu_memwrite;
                bus.mem_adr       = bus.cpu_adr;
                bus.mem_writedata = bus.cpu_writedata;
            end
            ST_LOAD: begin
                bus.mem_memwrite  = bus.in_valid;
                bus.mem_adr       = load_adr;
                bus.mem_writedata = bus.in_data;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - directed bench with a behavioural reference model of the run controller
module tb_mips_run_ctrl;
    import mips_pkg::*;

    localparam int W    = 8;
    localparam int AB   = 8;
    localparam int HOLD = 2;
    localparam int MAXC = 16;
    localparam int CW   = cycles_width(MAXC);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          run_start = 1'b0;
    logic          cpu_reset;
    logic [AB:0]   load_count;
    logic [W-1:0]  result;
    logic [CW-1:0] cycles;
    logic          done;
    logic          timeout;

    mips_run_ctrl_if #(.WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

    mips_run_ctrl #(
        .WIDTH        (W),
        .RAM_ADDR_BITS(AB),
        .HALT_ADR     (8'hFF),
        .HOLD_CYCLES  (HOLD),
        .MAX_CYCLES   (MAXC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .run_start (run_start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .load_count(load_count),
        .result    (result),
        .cycles    (cycles),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // exmem stand-in: written on the falling edge from the controller's RAM port
    logic [7:0] ram [256];
    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_memwrite) ram[bus.mem_adr] = bus.mem_writedata;
        end
    end

    // Fake core: halts at run cycle ram[0] with data ram[1], stores 0x33 to 0x80 at cycle 2,
    // and drives a bogus halt store while held in reset to prove it is masked.
    int core_cyc;
    initial begin
        bus.cpu_memwrite  = 1'b0;
        bus.cpu_adr       = '0;
        bus.cpu_writedata = '0;
        core_cyc          = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_reset) begin
                core_cyc          = 0;
                bus.cpu_memwrite  = 1'b1;
                bus.cpu_adr       = 8'hFF;
                bus.cpu_writedata = 8'hEE;
            end else begin
                if (core_cyc == int'(ram[0])) begin
                    bus.cpu_memwrite  = 1'b1;
                    bus.cpu_adr       = 8'hFF;
                    bus.cpu_writedata = ram[1];
                end else if (core_cyc == 2) begin
                    bus.cpu_memwrite  = 1'b1;
                    bus.cpu_adr       = 8'h80;
                    bus.cpu_writedata = 8'h33;
                end else begin
                    bus.cpu_memwrite  = 1'b0;
                    bus.cpu_adr       = 8'(8'h40 + core_cyc);
                    bus.cpu_writedata = 8'(core_cyc);
                end
                core_cyc++;
            end
        end
    end

    // Reference model: what the sequencer is doing, in transaction terms
    localparam int PARKED = 0, LOADING = 1, HOLDING = 2, RUNNING = 3;
    int         m_mode = PARKED;
    int         m_hold_left = 0;
    int         m_count = 0;
    int         m_cycles = 0;
    logic [7:0] m_result = 8'h00;
    bit         m_done = 1'b0;
    bit         m_timeout = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = PARKED; m_count = 0; m_cycles = 0;
            m_result = 8'h00; m_done = 1'b0; m_timeout = 1'b0;
        end else begin
            case (m_mode)
                PARKED: begin
                    if (load_start || run_start) begin
                        m_result = 8'h00; m_done = 1'b0; m_timeout = 1'b0;
                    end
                    if (load_start) begin
                        m_mode = LOADING; m_count = 0;
                    end else if (run_start) begin
                        m_mode = HOLDING; m_hold_left = HOLD;
                    end
                end
                LOADING: begin
                    if (bus.in_valid) begin
                        m_count++;
                        if (bus.in_last || m_count == (1 << AB)) begin
                            m_mode = HOLDING; m_hold_left = HOLD;
                        end
                    end
                end
                HOLDING: begin
                    m_cycles = 0;
                    m_hold_left--;
                    if (m_hold_left == 0) m_mode = RUNNING;
                end
                default: begin
                    m_cycles++;
                    if (bus.cpu_memwrite && bus.cpu_adr == 8'hFF) begin
                        m_result = bus.cpu_writedata; m_done = 1'b1; m_mode = PARKED;
                    end else if (m_cycles == MAXC) begin
                        m_timeout = 1'b1; m_mode = PARKED;
                    end
                end
            endcase
        end
    end

    logic [7:0] exp_ram [256];
    initial begin
        logic       e_we;
        logic [7:0] e_adr, e_wd;
        for (int a = 0; a < 256; a++) exp_ram[a] = 8'h00;
        forever begin
            @(negedge clk);
            e_we = 1'b0; e_adr = 8'h00; e_wd = 8'h00;
            if (m_mode == RUNNING) begin
                e_we = bus.cpu_memwrite; e_adr = bus.cpu_adr; e_wd = bus.cpu_writedata;
            end else if (m_mode == LOADING) begin
                e_we = bus.in_valid; e_adr = 8'(m_count % 256); e_wd = bus.in_data;
            end
            check("cpu_reset", cpu_reset, m_mode != RUNNING);
            check("in_ready", bus.in_ready, m_mode == LOADING);
            check("load_count", load_count, m_count);
            check("result", result, m_result);
            check("cycles", cycles, m_cycles);
            check("done", done, m_done);
            check("timeout", timeout, m_timeout);
            check("mem_memwrite", bus.mem_memwrite, e_we);
            check("mem_adr", bus.mem_adr, e_adr);
            check("mem_writedata", bus.mem_writedata, e_wd);
            if (e_we) exp_ram[e_adr] = e_wd;
        end
    end

    logic [7:0] img [300];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input bit with_last, output int accepted);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            bus.in_last  = with_last && (i == n - 1);
            if (bus.in_ready) accepted++;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_end(input string name, output int run_len);
        int k;
        k = 0;
        run_len = 0;
        while (!(done || timeout) && k < 300) begin
            if (!cpu_reset) run_len++;
            tick();
            k++;
        end
        if (k >= 300) check({name, "_end_bound"}, k, 0);
    endtask

    task automatic measure_release(input string name);
        int n;
        n = 1;
        while (cpu_reset && n < 20) begin
            tick();
            n++;
        end
        check({name, "_release_latency"}, n, HOLD + 1);
    endtask

    initial begin
        int acc, rl, r1, c1, bad;
        logic [7:0] fa, fb, ft;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        tick();
        tick();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_load_count", load_count, 0);
        check("rst_cycles", cycles, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_memwrite", bus.mem_memwrite, 0);
        reset = 1'b0;
        tick();

        // Fibonacci image: halt at run cycle 10 storing 0x0D
        img[0] = 8'd10; img[1] = 8'h0D; fa = 8'd1; fb = 8'd1;
        for (int k = 2; k < 64; k++) begin
            img[k] = fa; ft = fa + fb; fa = fb; fb = ft;
        end
        pulse_load();
        check("fib_in_ready", bus.in_ready, 1);
        stream(64, 1'b1, acc);
        check("fib_accepted", acc, 64);
        check("fib_load_count", load_count, 64);
        measure_release("fib");
        wait_end("fib", rl);
        check("fib_done", done, 1);
        check("fib_timeout", timeout, 0);
        check("fib_result", result, 8'h0D);
        check("fib_cycles", cycles, 11);
        check("fib_run_len", rl, 11);
        check("fib_ram_ff", ram[8'hFF], 8'h0D);
        check("fib_ram_80", ram[8'h80], 8'h33);
        check("fib_ram_63", ram[63], img[63]);

        // load_start and run_start together from DONE: load wins
        load_start = 1'b1; run_start = 1'b1;
        tick();
        load_start = 1'b0; run_start = 1'b0;
        check("both_in_ready", bus.in_ready, 1);
        check("both_done_clr", done, 0);
        stream(64, 1'b1, acc);
        wait_end("reload", rl);
        r1 = int'(result); c1 = int'(cycles);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("rerun_done_clr", done, 0);
        wait_end("rerun", rl);
        check("rerun_done", done, 1);
        check("rerun_result", result, r1);
        check("rerun_cycles", cycles, c1);
        check("rerun_result_lit", result, 8'h0D);
        check("rerun_load_count", load_count, 64);

        // Halt on the watchdog's terminal cycle
        img[0] = 8'd15; img[1] = 8'h5A;
        pulse_load();
        stream(2, 1'b1, acc);
        wait_end("tc_halt", rl);
        check("tc_halt_done", done, 1);
        check("tc_halt_timeout", timeout, 0);
        check("tc_halt_result", result, 8'h5A);
        check("tc_halt_cycles", cycles, 16);

        // No halt: watchdog expiry
        img[0] = 8'hFF; img[1] = 8'h00;
        pulse_load();
        stream(2, 1'b1, acc);
        measure_release("loop");
        wait_end("loop", rl);
        check("loop_timeout", timeout, 1);
        check("loop_done", done, 0);
        check("loop_cycles", cycles, 16);
        check("loop_run_len", rl, 16);
        check("loop_cpu_reset_17", cpu_reset, 1);

        // 260 bytes, no in_last: RAM fills and the stream closes
        img[0] = 8'd3; img[1] = 8'h77;
        for (int k = 2; k < 256; k++) img[k] = 8'(k * 7 + 1);
        for (int k = 256; k < 260; k++) img[k] = 8'hEE;
        pulse_load();
        stream(260, 1'b0, acc);
        check("full_accepted", acc, 256);
        check("full_load_count", load_count, 256);
        wait_end("full", rl);
        check("full_done", done, 1);
        check("full_result", result, 8'h77);
        check("full_cycles", cycles, 4);
        check("full_ram_0", ram[0], 8'd3);
        check("full_ram_2", ram[2], 8'd15);
        check("full_ram_3", ram[3], 8'd22);
        check("full_ram_fe", ram[8'hFE], 8'hF3);
        check("full_ram_ff", ram[8'hFF], 8'h77);

        // Reset midway through LOAD
        for (int k = 0; k < 10; k++) img[k] = 8'(8'hC0 + k);
        pulse_load();
        stream(10, 1'b0, acc);
        check("midload_load_count", load_count, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_cpu_reset", cpu_reset, 1);
        check("midload_in_ready", bus.in_ready, 0);
        check("midload_load_count_clr", load_count, 0);
        check("midload_cycles_clr", cycles, 0);
        check("midload_status", {done, timeout, result}, 0);
        check("midload_ram_0", ram[0], 8'hC0);
        check("midload_ram_9", ram[9], 8'hC9);
        check("midload_ram_10", ram[10], 8'd71);

        // Reset midway through RUN, rerunning the partial image from IDLE
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int k = 0; k < HOLD + 5; k++) tick();
        check("midrun_running", cpu_reset, 0);
        check("midrun_cycles", cycles, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun_cpu_reset", cpu_reset, 1);
        check("midrun_cycles_clr", cycles, 0);
        check("midrun_status", {done, timeout, result}, 0);
        check("midrun_ram_5", ram[5], 8'hC5);
        tick();

        bad = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== exp_ram[a]) bad++;
        check("ram_vs_model", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end
endmodule
